arb_tcp_tx_bridge: RTL and testbench



---
 rtl/arb_tcp_tx_bridge.sv | 133 +++++++++++++
 tb/tb_arb_tcp_tx_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_tcp_tx_bridge.sv
// Buffers 32-bit arbiter words in a circular FIFO and serialises them LSB-first
// onto the 8-bit SiTCP transmit interface, one byte per clock when not back-pressured.
module arb_tcp_tx_bridge #(
    parameter int DEPTH           = 1024,
    parameter int NEAR_FULL_LEVEL = 768,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic          BUS_CLK,
    input  logic          BUS_RST,
    input  logic          ARB_WRITE_OUT,
    input  logic [31:0]   ARB_DATA_OUT,
    output logic          ARB_READY_OUT,
    output logic          FIFO_FULL,
    output logic          FIFO_NEAR_FULL,
    output logic [AW:0]   FIFO_SIZE,
    output logic [7:0]    LOST_CNT,
    input  logic          TCP_OPEN,
    input  logic          TCP_TX_FULL,
    output logic          TCP_TX_WR,
    output logic [7:0]    TCP_TX_DATA
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] NEAR_LEVEL = (AW + 1)'(NEAR_FULL_LEVEL);
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    lost_q, lost_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic          full, push, drop, pop, tx_wr;

    assign full = (count_q == FULL_LEVEL);
    assign push = ARB_WRITE_OUT & ~full;
    assign drop = ARB_WRITE_OUT & full;

    // Serialiser: a pop always reloads the shift register with the head word.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        tx_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && TCP_OPEN) begin
                    pop     = 1'b1;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_wr = TCP_OPEN & ~TCP_TX_FULL;
                if (tx_wr) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (count_q != '0) begin
                        pop   = 1'b1;
                        idx_d = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d  = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        lost_d   = lost_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        if (drop && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lost_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lost_q   <= lost_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge BUS_CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= ARB_DATA_OUT;
        end
    end

    assign ARB_READY_OUT  = ~full;
    assign FIFO_FULL      = full;
    assign FIFO_NEAR_FULL = (count_q >= NEAR_LEVEL);
    assign FIFO_SIZE      = count_q;
    assign LOST_CNT       = lost_q;
    assign TCP_TX_WR      = tx_wr;
    assign TCP_TX_DATA    = (state_q == SEND) ? shift_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_arb_tcp_tx_bridge.sv
// Directed self-checking bench for arb_tcp_tx_bridge: single word, back-pressure,
// fill/overflow, push-while-full, connection drop and asynchronous reset.
module tb_arb_tcp_tx_bridge;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic        ARB_WRITE_OUT;
    logic [31:0] ARB_DATA_OUT;
    logic        ARB_READY_OUT;
    logic        FIFO_FULL;
    logic        FIFO_NEAR_FULL;
    logic [10:0] FIFO_SIZE;
    logic [7:0]  LOST_CNT;
    logic        TCP_OPEN;
    logic        TCP_TX_FULL;
    logic        TCP_TX_WR;
    logic [7:0]  TCP_TX_DATA;

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;
    int wrWhileFull = 0;
    logic [7:0]  rxBytes[$];
    int          rxCycles[$];
    logic [31:0] expWords[$];

    arb_tcp_tx_bridge #(.DEPTH(1024), .NEAR_FULL_LEVEL(768)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .ARB_WRITE_OUT(ARB_WRITE_OUT), .ARB_DATA_OUT(ARB_DATA_OUT),
        .ARB_READY_OUT(ARB_READY_OUT), .FIFO_FULL(FIFO_FULL),
        .FIFO_NEAR_FULL(FIFO_NEAR_FULL), .FIFO_SIZE(FIFO_SIZE),
        .LOST_CNT(LOST_CNT), .TCP_OPEN(TCP_OPEN), .TCP_TX_FULL(TCP_TX_FULL),
        .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    always @(posedge BUS_CLK) cycleCount <= cycleCount + 1;

    // Byte monitor: samples the strobe late in each cycle, just before the accepting edge.
    always @(negedge BUS_CLK) begin
        #2;
        if (TCP_TX_WR === 1'b1) begin
            rxBytes.push_back(TCP_TX_DATA);
            rxCycles.push_back(cycleCount);
            if (TCP_TX_FULL) wrWhileFull++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] data,
                                 input logic open, input logic txFull);
        @(negedge BUS_CLK);
        ARB_WRITE_OUT = wr;
        ARB_DATA_OUT  = data;
        TCP_OPEN      = open;
        TCP_TX_FULL   = txFull;
    endtask

    task automatic doReset();
        @(negedge BUS_CLK);
        BUS_RST = 1'b1;
        ARB_WRITE_OUT = 1'b0;
        ARB_DATA_OUT  = '0;
        TCP_OPEN      = 1'b0;
        TCP_TX_FULL   = 1'b0;
        repeat (2) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        rxBytes.delete();
        rxCycles.delete();
        expWords.delete();
    endtask

    task automatic waitBytes(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge BUS_CLK);
            #3;
            if (rxBytes.size() >= n) break;
        end
        checkOutput(tag, 32'(rxBytes.size() >= n), 32'd1);
    endtask

    task automatic checkStream(input string tag);
        int errs = 0;
        if (rxBytes.size() != expWords.size() * 4) errs++;
        for (int w = 0; w < expWords.size() && errs == 0; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (rxBytes[w*4+b] !== expWords[w][b*8 +: 8]) errs++;
            end
        end
        checkOutput(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        int wrCyc;
        int accepted;
        int badSize;
        int sawLow;
        int gaps;
        logic [31:0] nextVal;

        BUS_RST = 1'b1;
        ARB_WRITE_OUT = 1'b0;
        ARB_DATA_OUT  = '0;
        TCP_OPEN      = 1'b0;
        TCP_TX_FULL   = 1'b0;
        #12;
        checkOutput("rst_ready", 32'(ARB_READY_OUT), 32'd1);
        checkOutput("rst_full", 32'(FIFO_FULL), 32'd0);
        checkOutput("rst_near", 32'(FIFO_NEAR_FULL), 32'd0);
        checkOutput("rst_size", 32'(FIFO_SIZE), 32'd0);
        checkOutput("rst_lost", 32'(LOST_CNT), 32'd0);
        checkOutput("rst_wr", 32'(TCP_TX_WR), 32'd0);
        checkOutput("rst_data", 32'(TCP_TX_DATA), 32'd0);

        // Single word: four strobes, first one two cycles after the write edge.
        doReset();
        applyStimulus(1'b1, 32'h44332211, 1'b1, 1'b0);
        wrCyc = cycleCount;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(4, 20, "single_timeout");
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        expWords.push_back(32'h44332211);
        checkStream("single_bytes");
        checkOutput("single_first_cyc", 32'(rxCycles[0]), 32'(wrCyc + 2));
        checkOutput("single_last_cyc", 32'(rxCycles[3]), 32'(wrCyc + 5));
        checkOutput("single_size_end", 32'(FIFO_SIZE), 32'd0);
        checkOutput("single_wr_end", 32'(TCP_TX_WR), 32'd0);

        // Back-pressure with pseudo-random TCP_TX_FULL.
        doReset();
        wrWhileFull = 0;
        expWords.push_back(32'hA3A2A1A0);
        expWords.push_back(32'hB3B2B1B0);
        expWords.push_back(32'hC3C2C1C0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, expWords[i], 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(12, 20, "bp_timeout");
        checkStream("bp_bytes");
        checkOutput("bp_wr_while_full", 32'(wrWhileFull), 32'd0);

        // Fill with the connection closed, then overflow, then drain.
        doReset();
        for (int k = 0; k < 1024; k++) begin
            nextVal = $urandom();
            expWords.push_back(nextVal);
            applyStimulus(1'b1, nextVal, 1'b0, 1'b0);
            if (k == 767) checkOutput("fill_near_767", 32'(FIFO_NEAR_FULL), 32'd0);
            if (k == 768) checkOutput("fill_near_768", 32'(FIFO_NEAR_FULL), 32'd1);
            if (k == 1023) begin
                checkOutput("fill_full_1023", 32'(FIFO_FULL), 32'd0);
                checkOutput("fill_ready_1023", 32'(ARB_READY_OUT), 32'd1);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("fill_full_1024", 32'(FIFO_FULL), 32'd1);
        checkOutput("fill_ready_1024", 32'(ARB_READY_OUT), 32'd0);
        checkOutput("fill_size_1024", 32'(FIFO_SIZE), 32'd1024);
        for (int k = 0; k < 300; k++) applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("fill_lost_sat", 32'(LOST_CNT), 32'd255);
        checkOutput("fill_size_after_drop", 32'(FIFO_SIZE), 32'd1024);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(4096, 4400, "drain_timeout");
        checkStream("drain_bytes");
        gaps = 0;
        for (int i = 1; i < rxCycles.size(); i++) if (rxCycles[i] != rxCycles[0] + i) gaps++;
        checkOutput("drain_contiguous", 32'(gaps), 32'd0);

        // Push held high while full and draining.
        doReset();
        for (int k = 0; k < 1024; k++) begin
            nextVal = 32'h5000_0000 + 32'(k);
            expWords.push_back(nextVal);
            applyStimulus(1'b1, nextVal, 1'b0, 1'b0);
        end
        nextVal = 32'h6000_0000;
        accepted = 0;
        badSize = 0;
        sawLow = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, nextVal, 1'b1, 1'b0);
            #1;
            if (FIFO_SIZE != 11'd1023 && FIFO_SIZE != 11'd1024) badSize++;
            if (FIFO_SIZE == 11'd1023) sawLow = 1;
            if (ARB_READY_OUT) begin
                expWords.push_back(nextVal);
                nextVal++;
                accepted++;
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("pp_size_range", 32'(badSize), 32'd0);
        checkOutput("pp_saw_1023", 32'(sawLow), 32'd1);
        checkOutput("pp_accepted_some", 32'(accepted >= 10), 32'd1);
        waitBytes((1024 + accepted) * 4, 4600, "pp_timeout");
        checkStream("pp_bytes");

        // Connection drops after byte 1 and later comes back.
        doReset();
        applyStimulus(1'b1, 32'h87654321, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(2, 20, "drop_timeout1");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("drop_no_strobe_wr", 32'(TCP_TX_WR), 32'd0);
        checkOutput("drop_count_held", 32'(rxBytes.size()), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(4, 10, "drop_timeout2");
        expWords.push_back(32'h87654321);
        checkStream("drop_bytes");

        // Asynchronous reset in the middle of a word.
        doReset();
        applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        waitBytes(1, 10, "arst_timeout");
        @(negedge BUS_CLK);
        #1;
        BUS_RST = 1'b1;
        #1;
        checkOutput("arst_wr", 32'(TCP_TX_WR), 32'd0);
        checkOutput("arst_data", 32'(TCP_TX_DATA), 32'd0);
        checkOutput("arst_size", 32'(FIFO_SIZE), 32'd0);
        checkOutput("arst_ready", 32'(ARB_READY_OUT), 32'd1);
        checkOutput("arst_full", 32'(FIFO_FULL), 32'd0);
        repeat (2) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        rxBytes.delete();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #3;
        checkOutput("arst_no_stale", 32'(rxBytes.size()), 32'd0);
        checkOutput("arst_size_after", 32'(FIFO_SIZE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
